mtimer: RTL and testbench
=========================

Name: mtimer

Overview:
- Memory-mapped machine timer that drives the processor's `timer_interrupt` input. It sits directly upstream of the core's CSR/trap logic.
- It shares the MEM-stage data bus with `data_mem`, using the same `rd_en`/`wr_en`/`addr` signalling, and decodes its own address window.
- It keeps a free-running 64-bit `mtime` (with a programmable prescaler) and a 64-bit `mtimecmp`, and raises a level interrupt when `mtime >= mtimecmp`.

Parameters:
- BASE_ADDR, 32'h0000_0400, byte base of the 32-byte register window; must be 32-byte aligned.
- PRESC_W, 8, width of the prescaler divisor field.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp`; the default means no interrupt after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rd_en  in  1  bus read strobe (MEM stage)
- wr_en  in  1  bus write strobe (MEM stage)
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- hit  out  1  addr lies in the window and (rd_en | wr_en); the top level uses it to mux `rdata` against `data_mem`
- timer_interrupt  out  1  registered level interrupt

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Window and access:
  - Window hit when `addr[31:5] == BASE_ADDR[31:5]`; offset is `addr[4:2]`.
  - `addr[1:0]` is ignored; only word accesses are defined.
- Register map (offset, name, access):
  - 0x00 MTIME_LO, RW
  - 0x04 MTIME_HI, RW
  - 0x08 MTIMECMP_LO, RW
  - 0x0C MTIMECMP_HI, RW
  - 0x10 CTRL, RW: bit0 EN, bit1 IE, bits[8+PRESC_W-1:8] DIV; all other bits read 0
  - 0x14 MTIME_HI_SNAP, RO
  - 0x18 and 0x1C read 0; writes to them are ignored
- Reset values:
  - `mtime` = 0, `mtimecmp` = CMP_RST, CTRL = 0, snapshot = 0, prescaler count = 0
  - `timer_interrupt` = 0
  - `rdata` = 0 whenever there is no read hit
- Prescaler:
  - When EN=1, the prescaler count increments each cycle.
  - When count == DIV, a tick fires and the count returns to 0. DIV=0 therefore ticks every cycle; DIV=N ticks every N+1 cycles.
  - When EN=0, the count holds and no ticks occur.
  - A write to CTRL clears the count to 0 in that same edge.
- Counter:
  - On a tick, `mtime <= mtime + 1` with full 64-bit carry. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority: the written half takes `wdata`, the other half holds, and the increment is lost.
- Atomic read:
  - A read hit on MTIME_LO returns `mtime[31:0]` and, at the clock edge, latches `mtime[63:32]` into the snapshot register.
  - MTIME_HI_SNAP returns the snapshot register.
  - MTIME_HI returns the live upper word.
- Read/write collision: when `rd_en` and `wr_en` are both high, the write takes effect at the edge and `rdata` shows the pre-write value.
- Interrupt:
  - Each cycle, `timer_interrupt <= IE & (mtime >= mtimecmp)`, an unsigned 64-bit compare on the current register values.
  - Latency is 1 cycle from a register update to the interrupt.
  - The interrupt is level-type and stays asserted until software raises `mtimecmp`, clears IE, or rewrites `mtime`. There is no write-to-clear.
  - Software writes the two `mtimecmp` halves independently; a transient match between the two writes is permitted.
- Reset mid-operation: asserting `rst` asynchronously forces every register to its reset value, including dropping `timer_interrupt` immediately. Normal operation resumes on the first edge after release.

Decomposition:
- A shared package `mtimer_pkg` holds:
  - the offset constants OFF_MTIME_LO … OFF_MTIME_HI_SNAP
  - CTRL bit-index constants (CTRL_EN, CTRL_IE, CTRL_DIV_LSB)
  - a packed struct `ctrl_t` holding {div, ie, en}
- One sub-module, `mtimer_presc`: prescaler counter with enable, synchronous clear and tick output.
- The register file, compare logic and read mux stay in `mtimer`.

Test Plan:
- Reset default: release `rst`, write CTRL=0x3 (EN=1, IE=1, DIV=0), run 10 cycles → MTIME_LO reads 10 ±1 (exact value is bench-timed), `timer_interrupt` stays 0 because `mtimecmp` = all-ones.
- Prescaler: write CTRL = 0x0403 (DIV=4), run 50 cycles → `mtime` advances by exactly 10. Then set EN=0 and run 20 cycles → `mtime` is unchanged.
- Interrupt timing: write MTIMECMP_HI=0 and MTIMECMP_LO=100 with DIV=0, EN=1, IE=1 → `timer_interrupt` rises the cycle after `mtime` reaches 100 and stays high. Then write MTIMECMP_LO=500 → it falls 1 cycle later.
- Carry and atomic read: write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE, HI=0, run 2 ticks → MTIME_LO reads 0 and MTIME_HI_SNAP reads 1. Separately, load `mtime` = all-ones, tick once → `mtime` = 0.
- Write/tick collision: with DIV=0, EN=1, write MTIME_LO=0x55 → next cycle reads 0x55 (no +1). Same-cycle rd_en+wr_en on MTIMECMP_LO → `rdata` returns the old value.
- Async reset mid-count: with `timer_interrupt`=1, pulse `rst` low between clock edges → `timer_interrupt` drops immediately, all registers read their reset values, and `hit` is 0 for an access to BASE_ADDR+0x20.

Source files
------------

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared constants and types for the memory-mapped machine timer.
//   - register offsets within the 32-byte window (word index, addr[4:2])
//   - CTRL bit positions
//   - ctrl_t packed control register {div, ie, en}
package mtimer_pkg;

    typedef logic [2:0] off_t;

    localparam off_t OFF_MTIME_LO      = 3'd0;
    localparam off_t OFF_MTIME_HI      = 3'd1;
    localparam off_t OFF_MTIMECMP_LO   = 3'd2;
    localparam off_t OFF_MTIMECMP_HI   = 3'd3;
    localparam off_t OFF_CTRL          = 3'd4;
    localparam off_t OFF_MTIME_HI_SNAP = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_DIV_LSB = 8;

    // The DIV field can occupy everything above CTRL_DIV_LSB; the top level
    // masks it down to the configured prescaler width.
    localparam int DIV_W_MAX = 32 - CTRL_DIV_LSB;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        logic                 ie;
        logic                 en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        return {c.div, 6'b0, c.ie, c.en};
    endfunction

endpackage

// File: rtl/mtimer_if.sv
// mtimer_if: MEM-stage data bus shared with data_mem.
//   rd_en, wr_en : read / write strobes
//   addr, wdata  : byte address and write data
//   rdata        : combinational read data (0 when not a read hit)
//   hit          : address in the timer window and a strobe is active
interface mtimer_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output rd_en, wr_en, addr, wdata, input rdata, hit);
    modport slave  (input rd_en, wr_en, addr, wdata, output rdata, hit);
endinterface

// File: rtl/mtimer_presc.sv
// mtimer_presc: prescaler for the machine timer.
//   clk, rst : clock, asynchronous active-low reset
//   en       : count enable (count holds when low)
//   clr      : synchronous clear, wins over counting
//   div      : divisor; tick every div+1 enabled cycles
//   tick     : one-cycle pulse when the count reaches div
module mtimer_presc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit machine timer with prescaler and level interrupt.
//   clk, rst        : clock, asynchronous active-low reset
//   bus             : mtimer_if.slave (rd_en, wr_en, addr, wdata -> rdata, hit)
//   timer_interrupt : registered IE & (mtime >= mtimecmp)
// Registers (word offset): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
// 4 CTRL {DIV[8+:PRESC_W], IE[1], EN[0]}, 5 MTIME_HI_SNAP (RO), 6-7 read 0.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          PRESC_W   = 8,
    parameter logic [63:0] CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst,
    mtimer_if.slave  bus,
    output logic     timer_interrupt
);

    localparam logic [DIV_W_MAX-1:0] DIV_MASK =
        DIV_W_MAX'((64'd1 << PRESC_W) - 64'd1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] snap;
    ctrl_t       ctrl;
    logic        tick;
    logic        in_win;
    logic        rd_hit;
    logic        wr_hit;
    off_t        off;
    logic        unused_addr;

    // Only word accesses are defined; the byte lane bits are dropped.
    assign unused_addr = ^bus.addr[1:0];

    assign in_win  = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off     = bus.addr[4:2];
    assign bus.hit = in_win && (bus.rd_en || bus.wr_en);
    assign rd_hit  = in_win && bus.rd_en;
    assign wr_hit  = in_win && bus.wr_en;

    mtimer_presc #(.W(PRESC_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl.en),
        .clr  (wr_hit && (off == OFF_CTRL)),
        .div  (ctrl.div[PRESC_W-1:0]),
        .tick (tick)
    );

    // A software write to either mtime half overrides a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr_hit && (off == OFF_MTIME_LO)) begin
            mtime[31:0] <= bus.wdata;
        end else if (wr_hit && (off == OFF_MTIME_HI)) begin
            mtime[63:32] <= bus.wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= CMP_RST;
            ctrl     <= '0;
        end else if (wr_hit) begin
            case (off)
                OFF_MTIMECMP_LO: mtimecmp[31:0]  <= bus.wdata;
                OFF_MTIMECMP_HI: mtimecmp[63:32] <= bus.wdata;
                OFF_CTRL: begin
                    ctrl.en  <= bus.wdata[CTRL_EN];
                    ctrl.ie  <= bus.wdata[CTRL_IE];
                    ctrl.div <= bus.wdata[31:CTRL_DIV_LSB] & DIV_MASK;
                end
                default: ;
            endcase
        end
    end

    // Reading MTIME_LO freezes the upper word so a later MTIME_HI_SNAP read
    // pairs with it, even if a carry happened in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
        end else if (rd_hit && (off == OFF_MTIME_LO)) begin
            snap <= mtime[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= ctrl.ie && (mtime >= mtimecmp);
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (rd_hit) begin
            case (off)
                OFF_MTIME_LO:      bus.rdata = mtime[31:0];
                OFF_MTIME_HI:      bus.rdata = mtime[63:32];
                OFF_MTIMECMP_LO:   bus.rdata = mtimecmp[31:0];
                OFF_MTIMECMP_HI:   bus.rdata = mtimecmp[63:32];
                OFF_CTRL:          bus.rdata = ctrl_to_word(ctrl);
                OFF_MTIME_HI_SNAP: bus.rdata = snap;
                default:           bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq;

    mtimer_if bus_if ();

    mtimer #(
        .BASE_ADDR (BASE),
        .PRESC_W   (8),
        .CMP_RST   (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_if),
        .timer_interrupt (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: timer state as plain integers, advanced once per clock edge.
    longint unsigned m_time, m_cmp;
    bit              m_en, m_ie, m_irq;
    int unsigned     m_div, m_cnt;
    logic [31:0]     m_snap;

    function automatic void m_reset();
        m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en = 0; m_ie = 0; m_div = 0; m_cnt = 0; m_snap = 0; m_irq = 0;
    endfunction

    function automatic bit m_in_win(logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [31:0] m_read(int off);
        case (off)
            0: return m_time[31:0];
            1: return m_time[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return (m_div << 8) | (32'(m_ie) << 1) | 32'(m_en);
            5: return m_snap;
            default: return 0;
        endcase
    endfunction

    function automatic void m_step(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
        bit              h    = m_in_win(a);
        int              off  = int'(a[4:2]);
        bit              tick = m_en && (m_cnt == m_div);
        bit              nirq = m_ie && (m_time >= m_cmp);
        longint unsigned nt   = m_time;
        if (h && wr && off == 0)      nt = {m_time[63:32], d};
        else if (h && wr && off == 1) nt = {d, m_time[31:0]};
        else if (tick)                nt = m_time + 1;
        if (h && wr && off == 4) m_cnt = 0;
        else if (m_en)           m_cnt = tick ? 0 : m_cnt + 1;
        if (h && rd && off == 0) m_snap = m_time[63:32];
        if (h && wr && off == 2) m_cmp = {m_cmp[63:32], d};
        if (h && wr && off == 3) m_cmp = {d, m_cmp[31:0]};
        if (h && wr && off == 4) begin
            m_en = d[0]; m_ie = d[1]; m_div = 32'(d[15:8]);
        end
        m_time = nt;
        m_irq  = nirq;
    endfunction

    // One bus cycle: drive after the active edge, check combinational outputs at
    // the falling edge, advance the model at the rising edge, then check the IRQ.
    task automatic bus_a(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] v);
        bit h;
        bus_if.rd_en = rd; bus_if.wr_en = wr; bus_if.addr = a; bus_if.wdata = d;
        @(negedge clk);
        h = m_in_win(a) && (rd || wr);
        check("hit", 64'(bus_if.hit), 64'(h));
        check("rdata", 64'(bus_if.rdata), 64'((h && rd) ? m_read(int'(a[4:2])) : 32'd0));
        v = bus_if.rdata;
        @(posedge clk);
        m_step(rd, wr, a, d);
        #1;
        check("irq", 64'(irq), 64'(m_irq));
        bus_if.rd_en = 1'b0; bus_if.wr_en = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        logic [31:0] v;
        bus_a(1'b0, 1'b1, BASE + 32'(off * 4), d, v);
    endtask

    task automatic rd(input int off, output logic [31:0] v);
        bus_a(1'b1, 1'b0, BASE + 32'(off * 4), 32'd0, v);
    endtask

    task automatic idle(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) bus_a(1'b0, 1'b0, 32'd0, 32'd0, v);
    endtask

    logic [31:0] v, v0, v1, v2;
    logic [31:0] rst_exp [8];
    int          k;

    initial begin
        bus_if.rd_en = 0; bus_if.wr_en = 0; bus_if.addr = 0; bus_if.wdata = 0;
        rst_exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); m_step(0, 0, 0, 0); #1;

        // reset values
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            check($sformatf("rst_val%0d", i), 64'(v), 64'(rst_exp[i]));
        end

        // free run with DIV=0: ten ticks after enabling
        wr(4, 32'h3);
        idle(10);
        rd(0, v);
        check("run10_near", 64'(v >= 9 && v <= 11), 64'd1);
        check("run10_irq", 64'(irq), 64'd0);

        // prescaler DIV=4 over 50 cycles -> 10 ticks, then frozen
        wr(4, 32'h0400);
        rd(0, v0);
        wr(4, 32'h0403);
        idle(49);
        wr(4, 32'h0402);
        rd(0, v1);
        check("presc_delta", 64'(v1 - v0), 64'd10);
        idle(20);
        rd(0, v2);
        check("presc_hold", 64'(v2), 64'(v1));

        // interrupt rises one cycle after mtime reaches 100
        wr(4, 32'h2);
        wr(1, 32'd0);
        wr(0, 32'd90);
        wr(3, 32'd0);
        wr(2, 32'd100);
        wr(4, 32'h3);
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            idle(1);
            if (irq === 1'b1) begin k = i; break; end
        end
        check("irq_rise_cycle", 64'(k), 64'd11);
        idle(5);
        check("irq_level", 64'(irq), 64'd1);
        wr(2, 32'd500);
        check("irq_fall_lat0", 64'(irq), 64'd1);
        idle(1);
        check("irq_fall_lat1", 64'(irq), 64'd0);

        // 32-bit carry and snapshot
        wr(4, 32'h0);
        wr(1, 32'd0);
        wr(0, 32'hFFFF_FFFE);
        wr(1, 32'd0);
        wr(4, 32'h1);
        idle(1);
        wr(4, 32'h0);
        rd(0, v);
        check("carry_lo", 64'(v), 64'd0);
        rd(5, v);
        check("carry_snap", 64'(v), 64'd1);
        rd(1, v);
        check("carry_hi", 64'(v), 64'd1);

        // 64-bit wrap
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        wr(4, 32'h1);
        wr(4, 32'h0);
        rd(0, v);
        check("wrap_lo", 64'(v), 64'd0);
        rd(1, v);
        check("wrap_hi", 64'(v), 64'd0);

        // write beats tick; read/write collision shows old value
        wr(4, 32'h1);
        idle(3);
        wr(0, 32'h55);
        rd(0, v);
        check("wr_over_tick", 64'(v), 64'h55);
        bus_a(1'b1, 1'b1, BASE + 32'h8, 32'h1234, v);
        check("rw_old", 64'(v), 64'd500);
        rd(2, v);
        check("rw_new", 64'(v), 64'h1234);

        // async reset while the interrupt is asserted
        wr(2, 32'd0);
        wr(3, 32'd0);
        wr(4, 32'h3);
        idle(2);
        check("pre_rst_irq", 64'(irq), 64'd1);
        #2 rst = 1'b0;
        m_reset();
        #1;
        check("rst_irq_drop", 64'(irq), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus_if.rd_en = 1'b1; bus_if.addr = BASE + 32'(i * 4);
            #1;
            check($sformatf("rst_mid%0d", i), 64'(bus_if.rdata), 64'(rst_exp[i]));
        end
        bus_if.addr = BASE + 32'h20;
        #1;
        check("hit_outside", 64'(bus_if.hit), 64'd0);
        bus_if.rd_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); m_step(0, 0, 0, 0); #1;
        check("post_rst_irq", 64'(irq), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int          off = int'($urandom_range(0, 7));
            bit          r   = 1'($urandom);
            bit          w   = 1'($urandom);
            logic [31:0] a   = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            logic [31:0] d   = $urandom;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            if (off == 4) d = d & 32'h0000_0303;
            if ((off == 2 || off == 3 || off == 1) && $urandom_range(0, 1) == 0) d = d & 32'h0000_00FF;
            bus_a(r, w, a, d, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
